// File: rtl/mult_bit_streamer.sv
// Multiplier operand streamer: takes one WIDTH-bit operand per valid/ready handshake
// and emits it LSB-first, one bit per bit_valid/bit_ready beat, tagged with index/last.
module mult_bit_streamer #(
    parameter int WIDTH      = 8,
    parameter int IDX_W      = 3,
    parameter int EARLY_TERM = 0
) (
    input  logic             i_clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             i_abort,
    output logic             bit_valid,
    input  logic             bit_ready,
    output logic             bit_out,
    output logic [IDX_W-1:0] bit_idx,
    output logic             bit_last,
    output logic             o_done
);
    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [IDX_W-1:0] idx;
    logic             last_bit;

    // The index limit always ends the stream, so idx can never wrap even with early termination.
    assign last_bit  = (idx == LAST_IDX) || ((EARLY_TERM != 0) && (shreg[WIDTH-1:1] == '0));

    assign in_ready  = (state == IDLE);
    assign bit_valid = (state == SHIFT);
    assign bit_out   = bit_valid & shreg[0];
    assign bit_idx   = idx;
    assign bit_last  = bit_valid & last_bit;

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            shreg  <= '0;
            idx    <= '0;
            o_done <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shreg <= in_data;
                        idx   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Abort beats a coincident final handshake: the stream is dropped, not completed.
                    if (i_abort) begin
                        state <= IDLE;
                    end else if (bit_ready) begin
                        if (last_bit) begin
                            state  <= IDLE;
                            o_done <= 1'b1;
                        end else begin
                            shreg <= {1'b0, shreg[WIDTH-1:1]};
                            idx   <= idx + IDX_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_bit_streamer.sv
// Bench for mult_bit_streamer: two instances (EARLY_TERM 0 and 1) checked against
// a beat scoreboard filled when each operand is offered.
module tb_mult_bit_streamer;
    typedef struct packed {
        logic       b;
        logic [2:0] idx;
        logic       last;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       in_valid0 = 1'b0, abort0 = 1'b0, bit_ready0 = 1'b0;
    logic [7:0] in_data0 = 8'h00;
    logic       in_ready0, bit_valid0, bit_out0, bit_last0, o_done0;
    logic [2:0] bit_idx0;

    logic       in_valid1 = 1'b0, abort1 = 1'b0, bit_ready1 = 1'b0;
    logic [7:0] in_data1 = 8'h00;
    logic       in_ready1, bit_valid1, bit_out1, bit_last1, o_done1;
    logic [2:0] bit_idx1;

    beat_t sb0[$];
    beat_t sb1[$];
    int    checks = 0;
    int    fails  = 0;

    always #5 clk = ~clk;

    mult_bit_streamer #(.WIDTH(8), .IDX_W(3), .EARLY_TERM(0)) dut0 (
        .i_clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
        .in_data(in_data0), .i_abort(abort0), .bit_valid(bit_valid0), .bit_ready(bit_ready0),
        .bit_out(bit_out0), .bit_idx(bit_idx0), .bit_last(bit_last0), .o_done(o_done0)
    );

    mult_bit_streamer #(.WIDTH(8), .IDX_W(3), .EARLY_TERM(1)) dut1 (
        .i_clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_data(in_data1), .i_abort(abort1), .bit_valid(bit_valid1), .bit_ready(bit_ready1),
        .bit_out(bit_out1), .bit_idx(bit_idx1), .bit_last(bit_last1), .o_done(o_done1)
    );

    // Expected beats for one operand: LSB first, last at idx 7 or (early term) when nothing above is set.
    task automatic push_word(input int which, input logic [7:0] w, input bit et);
        beat_t      e;
        logic [7:0] rest;
        for (int i = 0; i < 8; i++) begin
            rest   = w >> (i + 1);
            e.b    = w[i];
            e.idx  = 3'(i);
            e.last = (i == 7) || (et && (rest == 8'h00));
            if (which == 0) sb0.push_back(e);
            else sb1.push_back(e);
            if (e.last) break;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({in_ready0, bit_valid0, bit_out0, bit_idx0, bit_last0, o_done0} !== 8'b1000_0000) begin
            fails++;
            $display("FAIL reset_dut0 got %b want 10000000",
                     {in_ready0, bit_valid0, bit_out0, bit_idx0, bit_last0, o_done0});
        end
        checks++;
        if ({in_ready1, bit_valid1, bit_out1, bit_idx1, bit_last1, o_done1} !== 8'b1000_0000) begin
            fails++;
            $display("FAIL reset_dut1 got %b want 10000000",
                     {in_ready1, bit_valid1, bit_out1, bit_idx1, bit_last1, o_done1});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int    done_cyc;
        beat_t got, exp;
        done_cyc = -1;
        push_word(0, 8'hB5, 1'b0);
        bit_ready0 = 1'b1; in_valid0 = 1'b1; in_data0 = 8'hB5;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            in_valid0 = 1'b0;
            if (o_done0) begin done_cyc = cyc; break; end
            if (bit_valid0 && bit_ready0) begin
                got = {bit_out0, bit_idx0, bit_last0};
                checks++;
                if (sb0.size() == 0) begin
                    fails++; $display("FAIL basic_beat unexpected beat %b", got);
                end else begin
                    exp = sb0.pop_front();
                    if (got !== exp) begin fails++; $display("FAIL basic_beat got %b want %b", got, exp); end
                end
            end
        end
        checks++;
        if (done_cyc != 9) begin fails++; $display("FAIL basic_latency got %0d want 9", done_cyc); end
        checks++;
        if (sb0.size() != 0) begin fails++; $display("FAIL basic_missing %0d beats left want 0", sb0.size()); end
        checks++;
        if (in_ready0 !== 1'b1) begin fails++; $display("FAIL basic_ready_at_done got %b want 1", in_ready0); end
        @(negedge clk);
        checks++;
        if (o_done0 !== 1'b0) begin fails++; $display("FAIL basic_done_pulse got %b want 0", o_done0); end
        sb0.delete();
    endtask

    task automatic test_early();
        logic [7:0] words [2];
        int         exp_done [2];
        int         done_cyc;
        beat_t      got, exp;
        words = '{8'h05, 8'h00};
        exp_done = '{4, 2};
        bit_ready1 = 1'b1;
        for (int w = 0; w < 2; w++) begin
            done_cyc = -1;
            push_word(1, words[w], 1'b1);
            in_valid1 = 1'b1; in_data1 = words[w];
            for (int cyc = 1; cyc <= 20; cyc++) begin
                @(negedge clk);
                in_valid1 = 1'b0;
                if (o_done1) begin done_cyc = cyc; break; end
                if (bit_valid1 && bit_ready1) begin
                    got = {bit_out1, bit_idx1, bit_last1};
                    checks++;
                    if (sb1.size() == 0) begin
                        fails++; $display("FAIL early_beat unexpected beat %b", got);
                    end else begin
                        exp = sb1.pop_front();
                        if (got !== exp) begin fails++; $display("FAIL early_beat got %b want %b", got, exp); end
                    end
                end
            end
            checks++;
            if (done_cyc != exp_done[w]) begin
                fails++; $display("FAIL early_len word %h got %0d want %0d", words[w], done_cyc, exp_done[w]);
            end
            checks++;
            if (sb1.size() != 0) begin fails++; $display("FAIL early_missing %0d beats left want 0", sb1.size()); end
            sb1.delete();
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [3:0] pat;
        logic [5:0] held, cur;
        bit         stalled, done_seen;
        beat_t      got, exp;
        pat = 4'b1001;
        stalled = 1'b0; done_seen = 1'b0; held = '0;
        push_word(0, 8'h81, 1'b0);
        bit_ready0 = 1'b1; in_valid0 = 1'b1; in_data0 = 8'h81;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            in_valid0 = 1'b0;
            bit_ready0 = pat[k % 4];
            if (o_done0) begin done_seen = 1'b1; break; end
            cur = {bit_valid0, bit_out0, bit_idx0, bit_last0};
            if (stalled) begin
                checks++;
                if (cur !== held) begin fails++; $display("FAIL bp_stable got %b want %b", cur, held); end
            end
            if (bit_valid0 && bit_ready0) begin
                stalled = 1'b0;
                got = {bit_out0, bit_idx0, bit_last0};
                checks++;
                if (sb0.size() == 0) begin
                    fails++; $display("FAIL bp_beat unexpected beat %b", got);
                end else begin
                    exp = sb0.pop_front();
                    if (got !== exp) begin fails++; $display("FAIL bp_beat got %b want %b", got, exp); end
                end
            end else if (bit_valid0) begin
                stalled = 1'b1;
                held = cur;
            end
        end
        checks++;
        if (!done_seen) begin fails++; $display("FAIL bp_timeout got no o_done want o_done"); end
        checks++;
        if (sb0.size() != 0) begin fails++; $display("FAIL bp_missing %0d beats left want 0", sb0.size()); end
        sb0.delete();
        bit_ready0 = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_abort();
        bit    saw_done, aborted;
        int    done_cyc;
        beat_t got, exp;
        saw_done = 1'b0; aborted = 1'b0;
        for (int i = 0; i < 3; i++) sb0.push_back(beat_t'({1'b1, 3'(i), 1'b0}));
        bit_ready0 = 1'b1; in_valid0 = 1'b1; in_data0 = 8'hFF;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            in_valid0 = 1'b0;
            if (o_done0) saw_done = 1'b1;
            if (aborted) break;
            if (bit_valid0 && bit_idx0 == 3'd3) begin
                abort0 = 1'b1; aborted = 1'b1;
            end else if (bit_valid0 && bit_ready0) begin
                got = {bit_out0, bit_idx0, bit_last0};
                checks++;
                if (sb0.size() == 0) begin
                    fails++; $display("FAIL abort_beat unexpected beat %b", got);
                end else begin
                    exp = sb0.pop_front();
                    if (got !== exp) begin fails++; $display("FAIL abort_beat got %b want %b", got, exp); end
                end
            end
        end
        abort0 = 1'b0;
        checks++;
        if ({in_ready0, bit_valid0, saw_done} !== 3'b100) begin
            fails++; $display("FAIL abort_idle got ready/valid/done %b want 100", {in_ready0, bit_valid0, saw_done});
        end
        checks++;
        if (sb0.size() != 0) begin fails++; $display("FAIL abort_prefix %0d beats left want 0", sb0.size()); end
        sb0.delete();

        // fresh word after the abort must stream cleanly
        done_cyc = -1;
        push_word(0, 8'h01, 1'b0);
        in_valid0 = 1'b1; in_data0 = 8'h01;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            in_valid0 = 1'b0;
            if (o_done0) begin done_cyc = cyc; break; end
            if (bit_valid0 && bit_ready0) begin
                got = {bit_out0, bit_idx0, bit_last0};
                checks++;
                if (sb0.size() == 0) begin
                    fails++; $display("FAIL abort_next_beat unexpected beat %b", got);
                end else begin
                    exp = sb0.pop_front();
                    if (got !== exp) begin fails++; $display("FAIL abort_next_beat got %b want %b", got, exp); end
                end
            end
        end
        checks++;
        if (done_cyc != 9 || sb0.size() != 0) begin
            fails++; $display("FAIL abort_next_len got %0d left %0d want 9 left 0", done_cyc, sb0.size());
        end
        sb0.delete();

        // abort coinciding with the final handshake: no o_done
        bit_ready1 = 1'b1; in_valid1 = 1'b1; in_data1 = 8'h00;
        @(negedge clk);
        in_valid1 = 1'b0;
        checks++;
        if ({bit_valid1, bit_last1} !== 2'b11) begin
            fails++; $display("FAIL abort_last_setup got valid/last %b want 11", {bit_valid1, bit_last1});
        end
        abort1 = 1'b1;
        @(negedge clk);
        checks++;
        if ({o_done1, in_ready1} !== 2'b01) begin
            fails++; $display("FAIL abort_vs_last got done/ready %b want 01", {o_done1, in_ready1});
        end

        // abort in IDLE is ignored; the offered word is accepted
        in_valid1 = 1'b1; in_data1 = 8'h05;
        push_word(1, 8'h05, 1'b1);
        done_cyc = -1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            abort1 = 1'b0; in_valid1 = 1'b0;
            if (o_done1) begin done_cyc = cyc; break; end
            if (bit_valid1 && bit_ready1) begin
                got = {bit_out1, bit_idx1, bit_last1};
                checks++;
                if (sb1.size() == 0) begin
                    fails++; $display("FAIL abort_idle_beat unexpected beat %b", got);
                end else begin
                    exp = sb1.pop_front();
                    if (got !== exp) begin fails++; $display("FAIL abort_idle_beat got %b want %b", got, exp); end
                end
            end
        end
        checks++;
        if (done_cyc != 4 || sb1.size() != 0) begin
            fails++; $display("FAIL abort_idle_len got %0d left %0d want 4 left 0", done_cyc, sb1.size());
        end
        sb1.delete();
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int    t0, phase;
        beat_t got, exp;
        t0 = 0; phase = 0;
        push_word(0, 8'h3C, 1'b0);
        bit_ready0 = 1'b1; in_valid0 = 1'b1; in_data0 = 8'h3C;
        for (int cyc = 1; cyc <= 40 && phase < 2; cyc++) begin
            @(negedge clk);
            if (o_done0) begin
                checks++;
                if (cyc - t0 != 9) begin fails++; $display("FAIL b2b_period got %0d want 9", cyc - t0); end
                checks++;
                if (in_ready0 !== 1'b1) begin fails++; $display("FAIL b2b_ready got %b want 1", in_ready0); end
                if (phase == 0) begin
                    in_data0 = 8'hC3;
                    push_word(0, 8'hC3, 1'b0);
                end else begin
                    in_valid0 = 1'b0;
                end
                t0 = cyc;
                phase++;
            end else begin
                in_data0 = 8'($urandom);
                if (phase == 1 && cyc == t0 + 1) begin
                    checks++;
                    if (bit_valid0 !== 1'b1) begin fails++; $display("FAIL b2b_accept got %b want 1", bit_valid0); end
                end
                if (bit_valid0 && bit_ready0) begin
                    got = {bit_out0, bit_idx0, bit_last0};
                    checks++;
                    if (sb0.size() == 0) begin
                        fails++; $display("FAIL b2b_beat unexpected beat %b", got);
                    end else begin
                        exp = sb0.pop_front();
                        if (got !== exp) begin fails++; $display("FAIL b2b_beat got %b want %b", got, exp); end
                    end
                end
            end
        end
        in_valid0 = 1'b0;
        checks++;
        if (phase != 2) begin fails++; $display("FAIL b2b_timeout got %0d streams want 2", phase); end
        checks++;
        if (sb0.size() != 0) begin fails++; $display("FAIL b2b_missing %0d beats left want 0", sb0.size()); end
        sb0.delete();
        @(negedge clk);
    endtask

    task automatic test_reset_midstream();
        bit_ready0 = 1'b1; in_valid0 = 1'b1; in_data0 = 8'hAA;
        @(negedge clk);
        in_valid0 = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bit_valid0, bit_idx0} !== 4'b1010) begin
            fails++; $display("FAIL rst_mid_setup got valid/idx %b want 1010", {bit_valid0, bit_idx0});
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready0, bit_valid0, o_done0, bit_idx0} !== 6'b100000) begin
            fails++; $display("FAIL rst_mid got ready/valid/done/idx %b want 100000",
                              {in_ready0, bit_valid0, o_done0, bit_idx0});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({in_ready0, bit_valid0, o_done0} !== 3'b100) begin
            fails++; $display("FAIL rst_mid_after got ready/valid/done %b want 100", {in_ready0, bit_valid0, o_done0});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_early();
        test_backpressure();
        test_abort();
        test_back_to_back();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end
endmodule
